// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//
// Programmable clock divider and tick generator. Produces a registered divided
// waveform (clk_out) with runtime-programmable period and high time, plus a
// one-cycle tick on the last cycle of every period. A new configuration is
// accepted through a valid/ready port, parked in pending registers and only
// made active at a period boundary, or at once while the divider is disabled,
// so a running period is never truncated or stretched.
//
// Build option:
//   CLK_DIV_PROG_DUTY_EN  defined   : cfg_high / DEFAULT_HIGH set the high time.
//                         undefined : high time is always period>>1 (floor 50%),
//                                     cfg_high is ignored, no high_pend register.
//
// Parameters:
//   CNT_W           width of counter, period and high-time fields
//   DEFAULT_PERIOD  period in clk cycles after reset
//   DEFAULT_HIGH    high time in clk cycles after reset (duty build only)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable; counter held at phase 0 while low
//   cfg_valid   in   new configuration offered
//   cfg_ready   out  configuration can be accepted (no config pending)
//   cfg_period  in   requested period in cycles, must be >= 2
//   cfg_high    in   requested high time in cycles
//   cfg_err     out  one-cycle pulse, offered config rejected (period < 2)
//   clk_out     out  divided waveform, registered
//   tick        out  one-cycle pulse on last cycle of each period, registered
// -----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 50000,
    parameter int unsigned DEFAULT_HIGH   = 25000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0] L_RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

    // Phase counter and active configuration
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_act;
    logic [CNT_W-1:0] w_high_act;

    // Pending configuration
    logic [CNT_W-1:0] r_per_pend;
    logic             r_pend_v;

    // Registered outputs
    logic             r_clk_out;
    logic             r_tick;
    logic             r_cfg_err;

    // Decoded events
    logic             w_wrap;
    logic             w_hs;
    logic             w_cfg_bad;
    logic             w_apply;
    logic [CNT_W-1:0] w_cnt_nxt;

`ifdef CLK_DIV_PROG_DUTY_EN
    localparam logic [CNT_W-1:0] L_RST_HIGH = CNT_W'(DEFAULT_HIGH);

    logic [CNT_W-1:0] r_high_act;
    logic [CNT_W-1:0] r_high_pend;

    assign w_high_act = r_high_act;
`else
    // High time tracks the period; the duty inputs exist only for port
    // compatibility with the programmable-duty build.
    localparam logic [CNT_W-1:0] L_UNUSED_DEFAULT_HIGH = CNT_W'(DEFAULT_HIGH);

    logic w_unused_cfg_high;

    assign w_unused_cfg_high = ^{cfg_high, L_UNUSED_DEFAULT_HIGH};
    assign w_high_act        = r_per_act >> 1;
`endif

    // Last cycle of the period while running.
    assign w_wrap    = en && (r_cnt == (r_per_act - L_ONE));
    assign w_hs      = cfg_valid && !r_pend_v;
    assign w_cfg_bad = cfg_period < L_MIN_PERIOD;
    // A handshake can only happen with nothing pending, so it never coincides
    // with an apply; a config captured on a wrap therefore waits for the next.
    assign w_apply   = r_pend_v && (w_wrap || !en);

    always_comb begin
        w_cnt_nxt = r_cnt + L_ONE;
        if (!en || w_wrap) begin
            w_cnt_nxt = '0;
        end
    end

    // Counter and waveform. Outputs are decoded from the current phase, so they
    // lag the counter by one cycle and phase 0 appears one cycle after the first
    // enabled edge. A high time >= period simply makes the compare always true.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= en && (r_cnt < w_high_act);
            r_tick    <= w_wrap;
        end
    end

    // Configuration handshake and apply. Applying also restarts the counter at
    // phase 0 (wrap or disabled), so the counter never exceeds the new period.
    // NOTE: the pending fields are reset too even though pend_v qualifies them;
    // they are a handful of flops, not a memory, and a known value keeps the
    // block free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_act   <= L_RST_PERIOD;
            r_per_pend  <= '0;
            r_pend_v    <= 1'b0;
            r_cfg_err   <= 1'b0;
`ifdef CLK_DIV_PROG_DUTY_EN
            r_high_act  <= L_RST_HIGH;
            r_high_pend <= '0;
`endif
        end else begin
            r_cfg_err <= 1'b0;

            if (w_apply) begin
                r_per_act  <= r_per_pend;
`ifdef CLK_DIV_PROG_DUTY_EN
                r_high_act <= r_high_pend;
`endif
                r_pend_v   <= 1'b0;
            end

            if (w_hs) begin
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_per_pend  <= cfg_period;
`ifdef CLK_DIV_PROG_DUTY_EN
                    r_high_pend <= cfg_high;
`endif
                    r_pend_v    <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready = !r_pend_v;
    assign cfg_err   = r_cfg_err;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
//
// Self-checking bench for clk_div_prog. The reference model describes each
// period as a list of (clk_out, tick) output cycles built from the active
// configuration when the period starts; configuration handling follows the
// handshake / pending / apply rules. Directed scenarios are followed by a
// randomized run.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DEF_P  = 10;
    localparam int unsigned DEF_H  = 5;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_prog #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_P),
        .DEFAULT_HIGH   (DEF_H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    logic [1:0] m_q[$];      // remaining {clk_out, tick} cycles of current period
    int         m_per;
    int         m_high;
    int         m_pper;
    int         m_phigh;
    bit         m_pv;
    bit         exp_clk;
    bit         exp_tick;
    bit         exp_err;
    bit         exp_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_per     = DEF_P;
`ifdef CLK_DIV_PROG_DUTY_EN
        m_high    = DEF_H;
`else
        m_high    = DEF_P / 2;
`endif
        m_pper    = 0;
        m_phigh   = 0;
        m_pv      = 1'b0;
        exp_clk   = 1'b0;
        exp_tick  = 1'b0;
        exp_err   = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic model_apply();
        m_per  = m_pper;
        m_high = m_phigh;
        m_pv   = 1'b0;
    endtask

    // One rising edge, using the inputs as sampled at that edge.
    task automatic model_edge();
        logic [1:0] e;
        bit         rdy;
        rdy     = !m_pv;
        exp_err = 1'b0;
        if (en) begin
            if (m_q.size() == 0) begin
                for (int i = 0; i < m_per; i++) begin
                    m_q.push_back({(i < m_high), (i == m_per - 1)});
                end
            end
            e        = m_q.pop_front();
            exp_clk  = e[1];
            exp_tick = e[0];
            // Period finished: pending config takes over for the next one.
            if (m_q.size() == 0 && m_pv) model_apply();
        end else begin
            m_q.delete();
            exp_clk  = 1'b0;
            exp_tick = 1'b0;
            if (m_pv) model_apply();
        end
        if (cfg_valid && rdy) begin
            if (int'(cfg_period) < 2) begin
                exp_err = 1'b1;
            end else begin
                m_pper  = int'(cfg_period);
`ifdef CLK_DIV_PROG_DUTY_EN
                m_phigh = int'(cfg_high);
`else
                m_phigh = int'(cfg_period) / 2;
`endif
                m_pv    = 1'b1;
            end
        end
        exp_ready = !m_pv;
    endtask

    // ---------------------------------------------------------------- driving
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("clk_out",   32'(clk_out),   32'(exp_clk));
        check("tick",      32'(tick),      32'(exp_tick));
        check("cfg_err",   32'(cfg_err),   32'(exp_err));
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        step();
        cfg_valid  = 1'b0;
    endtask

    // Advance until the next output cycle will be the given phase of a period.
    task automatic go_to_phase(input int ph);
        int guard;
        guard = 0;
        while (!(m_q.size() == m_per - ph) && guard < 100) begin
            step();
            guard++;
        end
        check("phase_reached", 32'(guard < 100), 32'd1);
    endtask

    int high_cnt;

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        model_reset();

        // Reset values
        #12;
        check("rst_clk_out",   32'(clk_out),   32'd0);
        check("rst_tick",      32'(tick),      32'd0);
        check("rst_cfg_err",   32'(cfg_err),   32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Default waveform
        en = 1'b1;
        run(25);
        high_cnt = 0;
        for (int i = 0; i < DEF_P; i++) begin
            step();
            high_cnt += int'(clk_out);
        end
        check("default_high_cycles", 32'(high_cnt), 32'(m_high));

        // Rejected config: period 1
        offer(1, 0);
        run(12);

        // Config at phase 3 of a period: period 4, high 1
        go_to_phase(3);
        offer(4, 1);
        run(20);

        // Constant low, then constant high
        offer(4, 0);
        run(12);
        offer(4, 7);
        run(12);

        // Pending config, then en drops mid-period
        offer(10, 5);
        run(4);
        go_to_phase(2);
        offer(6, 2);
        en = 1'b0;
        step();
        check("disabled_clk_out", 32'(clk_out), 32'd0);
        run(3);
        en = 1'b1;
        run(14);

        // Asynchronous reset with a config pending
        go_to_phase(1);
        offer(3, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clk_out",   32'(clk_out),   32'd0);
        check("async_tick",      32'(tick),      32'd0);
        check("async_cfg_ready", 32'(cfg_ready), 32'd1);
        check("async_cfg_err",   32'(cfg_err),   32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(22);

        // Odd period: 7 (floor-50% duty without the duty feature)
        offer(7, 2);
        run(21);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en         = ($urandom_range(0, 15) != 0);
            cfg_valid  = ($urandom_range(0, 4) == 0);
            cfg_period = CNT_W'($urandom_range(0, 12));
            cfg_high   = CNT_W'($urandom_range(0, 14));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable clock divider and tick generator, the parametrised successor to the fixed 50 MHz→1 kHz divider. Produces a divided clock-enable waveform `clk_out` with runtime-programmable period and high time, plus a one-cycle `tick` per period. Configuration is loaded through a valid/ready port and applied glitch-free at period boundaries. It sits between the system clock and the display-scan, key-debounce and timebase logic of the calculator design.

## Interface
Parameters:
- `CNT_W`, 32, width of counter, period and high-time fields
- `DEFAULT_PERIOD`, 50000, period in `clk` cycles after reset (1 kHz at 50 MHz)
- `DEFAULT_HIGH`, 25000, high time in `clk` cycles after reset

Ports:
- `clk`  in  1  system clock, 50 MHz, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable
- `cfg_valid`  in  1  new configuration offered
- `cfg_ready`  out  1  configuration can be accepted
- `cfg_period`  in  CNT_W  requested period in cycles, must be ≥ 2
- `cfg_high`  in  CNT_W  requested high time in cycles
- `cfg_err`  out  1  one-cycle pulse, offered config rejected
- `clk_out`  out  1  divided waveform, registered
- `tick`  out  1  one-cycle pulse on last cycle of each period, registered

## Operation
- Active registers: `per_act`, `high_act`. Pending registers: `per_pend`, `high_pend`, `pend_v`.
- Counter `cnt` counts 0 … `per_act`−1, then wraps to 0. Counts only while `en`=1. While `en`=0, `cnt` is forced to 0.
- `clk_out <= en && (cnt < high_act)`. `tick <= en && (cnt == per_act−1)`.
- `high_act` = 0 gives constant-0 `clk_out`. `high_act` ≥ `per_act` gives constant-1 `clk_out`. `tick` runs normally in both cases.
- `cfg_ready` = !`pend_v`. A handshake occurs when `cfg_valid && cfg_ready`.
- On a handshake with `cfg_period` < 2: config is discarded, `cfg_err` pulses for 1 cycle, and `pend_v` stays 0.
- On any other handshake: fields are captured into the pending registers and `pend_v` is set to 1.
- Pending config is applied (active ← pending, `pend_v` ← 0) on:
  - the cycle `cnt` wraps (`cnt == per_act−1` with `en`=1), or
  - any cycle with `en`=0.
- Simultaneous events:
  - A handshake in the same cycle as a wrap is captured to pending and applied at the next wrap, not the current one.
  - An apply and a new handshake cannot coincide, because `cfg_ready` is low while pending.
- Arithmetic is unsigned CNT_W-bit with no overflow: `cnt` never exceeds `per_act`−1.

## Timing
- Reset values:
  - Outputs: `clk_out`=0, `tick`=0, `cfg_err`=0, `cfg_ready`=1.
  - Internal: `cnt`=0, `per_act`=DEFAULT_PERIOD, `high_act`=DEFAULT_HIGH (or DEFAULT_PERIOD>>1 without the duty feature), `pend_v`=0.
- Reset is asynchronous. Asserting `rst_n` mid-operation forces all outputs and registers to their reset values immediately and discards any pending config.
- Latency:
  - `clk_out` and `tick` lag `cnt` by 1 cycle.
  - The first `clk_out` high appears 1 cycle after the first edge where `en`=1 is sampled.
- Steady state: `clk_out` period = `per_act` cycles, high for exactly `high_act` cycles, starting at phase 0. `tick` is high in the last output cycle of each period.
- `en` falling mid-period: `clk_out` and `tick` are 0 from the next cycle. Re-enabling restarts at phase 0.
- `cfg_ready` falls the cycle after a handshake and rises the cycle after the apply.
- `cfg_err` rises the cycle after the rejected handshake.
- A config change never truncates or stretches the period in progress.

## Configuration
- Macro `CLK_DIV_PROG_DUTY_EN`.
- Defined: `cfg_high` is captured and used as described above, giving programmable duty.
- Undefined:
  - `cfg_high` and `DEFAULT_HIGH` are ignored, and `high_act` always equals `per_act`>>1, giving a floor-50% duty.
  - For an odd period P, `clk_out` is high for (P−1)/2 cycles.
  - No `high_pend` register is built.

## Test plan
(Bench uses DEFAULT_PERIOD=10, DEFAULT_HIGH=5, CLK_DIV_PROG_DUTY_EN defined unless stated.)
- Reset, then `en`=1 → `clk_out` repeats 5 high / 5 low; `tick` pulses every 10 cycles, coincident with the last low cycle; `cfg_ready`=1.
- At cycle 3 of a period, offer period=4, high=1 → `cfg_ready` low until wrap; current period completes at 10 cycles; then 1 high / 3 low repeating.
- Offer period=1 → `cfg_err` one-cycle pulse, `cfg_ready` stays 1, waveform unchanged at 10/5.
- Offer period=4, high=0 → constant 0 with `tick` every 4 cycles. Then period=4, high=7 → constant 1 with `tick` every 4 cycles.
- With a pending config, drop `en` mid-period → `clk_out`=0 next cycle, config applied while disabled. Re-assert `en` → new waveform starts at phase 0.
- Assert `rst_n`=0 asynchronously mid-period with a config pending → outputs 0 without a clock edge. After release: 10/5 waveform, pending discarded.
- Macro undefined, period=7 → `clk_out` 3 high / 4 low; `cfg_high` has no effect.
